// File: rtl/draw_pkg.sv
// Shared draw-path types: span FSM states and the default pixel width.
package draw_pkg;

   typedef enum logic [1:0] {SPAN_IDLE, SPAN_BODY, SPAN_FLUSH} span_state_e;

   localparam int DRAW_PIXEL_W = 8;

endpackage

// File: rtl/lane_funnel_shift.sv
// Combinational funnel: selects LANES consecutive lanes from a 2*LANES window.
module lane_funnel_shift #(
   parameter  int LANE_W  = 8,
   parameter  int LANES   = 16,
   localparam int SHIFT_W = $clog2(LANES)
) (
   input  logic [2*LANES*LANE_W-1:0] win,
   input  logic [SHIFT_W-1:0]        shift,
   output logic [LANES*LANE_W-1:0]   lanes
);

   always_comb begin
      lanes = '0;
      for (int l = 0; l < LANES; l++) begin
         lanes[l*LANE_W +: LANE_W] = win[(l + int'(shift))*LANE_W +: LANE_W];
      end
   end

endmodule

// File: rtl/pixel_span_aligner.sv
// Realigns a span of pixel beats by a per-span lane shift, stitching each
// output beat from the carried beat and the incoming one.
module pixel_span_aligner
   import draw_pkg::*;
#(
   parameter  int PIXEL_W = DRAW_PIXEL_W,
   parameter  int LANES   = 16,
   localparam int SHIFT_W = $clog2(LANES)
) (
   input  logic                     clk_draw,
   input  logic                     rst_draw_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*PIXEL_W-1:0] in_pixels,
   input  logic [LANES-1:0]         in_mask,
   input  logic [SHIFT_W-1:0]       in_shift,
   input  logic                     in_first,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*PIXEL_W-1:0] out_pixels,
   output logic [LANES-1:0]         out_mask,
   output logic                     out_last,
   output logic                     err_abort
);

   localparam int BEAT_W = LANES*PIXEL_W;

   span_state_e state_q, state_d;

   logic [BEAT_W-1:0]  carry_p0;
   logic [LANES-1:0]   carry_mask_p0;
   logic [SHIFT_W-1:0] span_shift_p0;

   logic               vld_p1;
   logic [BEAT_W-1:0]  pix_p1;
   logic [LANES-1:0]   mask_p1;
   logic               last_p1;
   logic               err_p1;

   logic               out_free;
   logic               accept;
   logic               take_first;
   logic               load_out;
   logic               flush_load;
   logic               abort;

   logic [BEAT_W-1:0]  win_hi;
   logic [LANES-1:0]   wmask_hi;
   logic [BEAT_W-1:0]  fun_pix;
   logic [LANES-1:0]   fun_mask;

   assign out_free = !vld_p1 || out_ready;
   assign accept   = in_valid && in_ready;

   // The tail beat is stitched against an all-zero, all-invalid upper half.
   assign win_hi   = (state_q == SPAN_FLUSH) ? '0 : in_pixels;
   assign wmask_hi = (state_q == SPAN_FLUSH) ? '0 : in_mask;

   lane_funnel_shift #(
      .LANE_W (PIXEL_W),
      .LANES  (LANES)
   ) u_pix_funnel (
      .win   ({win_hi, carry_p0}),
      .shift (span_shift_p0),
      .lanes (fun_pix)
   );

   lane_funnel_shift #(
      .LANE_W (1),
      .LANES  (LANES)
   ) u_mask_funnel (
      .win   ({wmask_hi, carry_mask_p0}),
      .shift (span_shift_p0),
      .lanes (fun_mask)
   );

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      take_first = 1'b0;
      load_out   = 1'b0;
      flush_load = 1'b0;
      abort      = 1'b0;
      case (state_q)
         SPAN_IDLE: begin
            in_ready = out_free;
            if (in_valid && out_free) begin
               take_first = 1'b1;
               state_d    = in_last ? SPAN_FLUSH : SPAN_BODY;
            end
         end
         SPAN_BODY: begin
            in_ready = out_free;
            if (in_valid && out_free) begin
               // A fresh first beat mid-span drops the carry and restarts.
               if (in_first) begin
                  abort      = 1'b1;
                  take_first = 1'b1;
               end else begin
                  load_out   = 1'b1;
               end
               state_d = in_last ? SPAN_FLUSH : SPAN_BODY;
            end
         end
         SPAN_FLUSH: begin
            if (out_free) begin
               load_out   = 1'b1;
               flush_load = 1'b1;
               state_d    = SPAN_IDLE;
            end
         end
         default: state_d = SPAN_IDLE;
      endcase
   end

   always_ff @(posedge clk_draw or negedge rst_draw_n) begin
      if (!rst_draw_n) state_q <= SPAN_IDLE;
      else             state_q <= state_d;
   end

   // Stage p0: carry of the previous beat and the span's shift
   always_ff @(posedge clk_draw or negedge rst_draw_n) begin
      if (!rst_draw_n) begin
         carry_p0      <= '0;
         carry_mask_p0 <= '0;
         span_shift_p0 <= '0;
      end else begin
         if (accept) begin
            carry_p0      <= in_pixels;
            carry_mask_p0 <= in_mask;
         end
         if (take_first) span_shift_p0 <= in_shift;
      end
   end

   // Stage p1: registered output beat and abort pulse
   always_ff @(posedge clk_draw or negedge rst_draw_n) begin
      if (!rst_draw_n) begin
         vld_p1  <= 1'b0;
         pix_p1  <= '0;
         mask_p1 <= '0;
         last_p1 <= 1'b0;
         err_p1  <= 1'b0;
      end else begin
         err_p1 <= abort;
         if (load_out) begin
            vld_p1  <= 1'b1;
            pix_p1  <= fun_pix;
            mask_p1 <= fun_mask;
            last_p1 <= flush_load;
         end else if (out_ready) begin
            vld_p1  <= 1'b0;
         end
      end
   end

   assign out_valid  = vld_p1;
   assign out_pixels = pix_p1;
   assign out_mask   = mask_p1;
   assign out_last   = last_p1;
   assign err_abort  = err_p1;

endmodule
